// File: rtl/base_pkg.sv
// Shared types and elaboration helpers for the base FIFO library.
package base_pkg;

  typedef enum logic [0:0] {
    FIFO_MODE_STD,
    FIFO_MODE_FWFT
  } fifo_mode_e;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int unsigned clog2p1(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Enable-driven modulo-DEPTH counter used as a FIFO read or write pointer.
module fifo_ptr_wrap #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_ptr
);

  logic [WIDTH-1:0] ptr_q, ptr_d;

  // Wraps explicitly at DEPTH-1 so non-power-of-two depths work.
  always_comb begin
    ptr_d = ptr_q;
    if (i_clr) begin
      ptr_d = '0;
    end else if (i_en) begin
      ptr_d = (ptr_q == WIDTH'(DEPTH - 1)) ? '0 : ptr_q + WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign o_ptr = ptr_q;

endmodule

// File: rtl/reg_rst_y_mode_a_en_y.sv
// Enabled register with asynchronous active-low reset to a fixed value.
module reg_rst_y_mode_a_en_y #(
  parameter int unsigned           WIDTH   = 8,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_q <= RST_VAL;
    end else if (i_en) begin
      o_q <= i_d;
    end
  end

endmodule

// File: rtl/fifo_mode_s_ext.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, programmable
// almost-full/almost-empty, occupancy count, sticky error flags and flush.
module fifo_mode_s_ext
  import base_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned FWFT_MODE    = 0,
  parameter int unsigned AFULL_THRES  = FIFO_DEPTH - 1,
  parameter int unsigned AEMPTY_THRES = 1,
  parameter int unsigned PTRS_WIDTH   = $clog2(FIFO_DEPTH),
  parameter int unsigned CNT_WIDTH    = clog2p1(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clr,
  input  logic                  i_wr_en,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_full,
  output logic                  o_wr_afull,
  output logic                  o_ovf,
  input  logic                  i_rd_en,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid,
  output logic                  o_rd_empty,
  output logic                  o_rd_aempty,
  output logic                  o_udf,
  output logic [CNT_WIDTH-1:0]  o_cnt
);

  localparam fifo_mode_e Mode = (FWFT_MODE != 0) ? FIFO_MODE_FWFT : FIFO_MODE_STD;

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_mode_s_ext: FIFO_DEPTH must be at least 2");
  end
  if (AFULL_THRES > FIFO_DEPTH) begin : g_bad_afull
    $error("fifo_mode_s_ext: AFULL_THRES must not exceed FIFO_DEPTH");
  end
  if (AEMPTY_THRES >= FIFO_DEPTH) begin : g_bad_aempty
    $error("fifo_mode_s_ext: AEMPTY_THRES must be below FIFO_DEPTH");
  end

  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PTRS_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rd_head;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;
  logic                  ovf_q, udf_q;

  // Status is decoded from the registered count only.
  assign full   = (cnt_q == CNT_WIDTH'(FIFO_DEPTH));
  assign empty  = (cnt_q == '0);
  assign wr_acc = i_wr_en & ~full & ~i_clr;
  assign rd_acc = i_rd_en & ~empty & ~i_clr;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= i_clr ? 1'b0 : (ovf_q | (i_wr_en & full));
      udf_q <= i_clr ? 1'b0 : (udf_q | (i_rd_en & empty));
    end
  end

  fifo_ptr_wrap #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PTRS_WIDTH)
  ) u_wr_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_en    (wr_acc),
    .o_ptr   (wr_ptr)
  );

  fifo_ptr_wrap #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PTRS_WIDTH)
  ) u_rd_ptr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clr),
    .i_en    (rd_acc),
    .o_ptr   (rd_ptr)
  );

  // Flush leaves the storage untouched; only reset zeroes it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[wr_ptr] <= i_wr_data;
    end
  end

  assign rd_head = mem[rd_ptr];

  if (Mode == FIFO_MODE_FWFT) begin : g_fwft
    assign o_rd_data  = rd_head;
    assign o_rd_valid = ~empty;
  end else begin : g_std
    logic valid_q;

    reg_rst_y_mode_a_en_y #(
      .WIDTH   (DATA_WIDTH),
      .RST_VAL ('0)
    ) u_rd_data (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (rd_acc),
      .i_d     (rd_head),
      .o_q     (o_rd_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
      end
    end

    assign o_rd_valid = valid_q;
  end

  assign o_wr_full   = full;
  assign o_wr_afull  = (cnt_q >= CNT_WIDTH'(AFULL_THRES));
  assign o_rd_empty  = empty;
  assign o_rd_aempty = (cnt_q <= CNT_WIDTH'(AEMPTY_THRES));
  assign o_ovf       = ovf_q;
  assign o_udf       = udf_q;
  assign o_cnt       = cnt_q;

endmodule

// File: tb/tb_fifo_mode_s_ext.sv
// Bench for fifo_mode_s_ext: a depth-5 standard FIFO and a depth-4 FWFT FIFO
// checked every cycle against queue-based reference models.
module tb_fifo_mode_s_ext;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr     [2];
  logic       wr_en   [2];
  logic [7:0] wr_data [2];
  logic       rd_en   [2];
  logic [7:0] rd_data [2];
  logic       full    [2];
  logic       afull   [2];
  logic       ovf     [2];
  logic       valid   [2];
  logic       empty   [2];
  logic       aempty  [2];
  logic       udf     [2];
  logic [2:0] cnt     [2];

  int depth    [2] = '{5, 4};
  int afull_t  [2] = '{4, 3};
  int aempty_t [2] = '{1, 1};
  bit fwft     [2] = '{1'b0, 1'b1};

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_ovf   [2];
  logic       m_udf   [2];
  logic       m_valid [2];
  logic [7:0] m_rdata [2];

  always #5 clk = ~clk;

  fifo_mode_s_ext #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (5),
    .FWFT_MODE  (0)
  ) u_std (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clr       (clr[0]),
    .i_wr_en     (wr_en[0]),
    .i_wr_data   (wr_data[0]),
    .o_wr_full   (full[0]),
    .o_wr_afull  (afull[0]),
    .o_ovf       (ovf[0]),
    .i_rd_en     (rd_en[0]),
    .o_rd_data   (rd_data[0]),
    .o_rd_valid  (valid[0]),
    .o_rd_empty  (empty[0]),
    .o_rd_aempty (aempty[0]),
    .o_udf       (udf[0]),
    .o_cnt       (cnt[0])
  );

  fifo_mode_s_ext #(
    .DATA_WIDTH   (8),
    .FIFO_DEPTH   (4),
    .FWFT_MODE    (1),
    .AFULL_THRES  (3),
    .AEMPTY_THRES (1)
  ) u_fwft (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_clr       (clr[1]),
    .i_wr_en     (wr_en[1]),
    .i_wr_data   (wr_data[1]),
    .o_wr_full   (full[1]),
    .o_wr_afull  (afull[1]),
    .o_ovf       (ovf[1]),
    .i_rd_en     (rd_en[1]),
    .o_rd_data   (rd_data[1]),
    .o_rd_valid  (valid[1]),
    .o_rd_empty  (empty[1]),
    .o_rd_aempty (aempty[1]),
    .o_udf       (udf[1]),
    .o_cnt       (cnt[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int m_size(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [7:0] m_head(input int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  task automatic m_push(input int i, input logic [7:0] v);
    if (i == 0) q0.push_back(v);
    else        q1.push_back(v);
  endtask

  task automatic m_pop(input int i, output logic [7:0] v);
    if (i == 0) v = q0.pop_front();
    else        v = q1.pop_front();
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_ovf[i]   = 1'b0;
      m_udf[i]   = 1'b0;
      m_valid[i] = 1'b0;
      m_rdata[i] = 8'h00;
    end
  endtask

  // One clock edge of FIFO behaviour, using the occupancy before the edge.
  task automatic model_step(input int i);
    int         sz;
    bit         is_full, is_empty;
    logic [7:0] v;
    sz       = m_size(i);
    is_full  = (sz == depth[i]);
    is_empty = (sz == 0);
    if (clr[i]) begin
      if (i == 0) q0.delete();
      else        q1.delete();
      m_ovf[i]   = 1'b0;
      m_udf[i]   = 1'b0;
      m_valid[i] = 1'b0;
    end else begin
      if (wr_en[i] && is_full)  m_ovf[i] = 1'b1;
      if (rd_en[i] && is_empty) m_udf[i] = 1'b1;
      m_valid[i] = 1'b0;
      if (rd_en[i] && !is_empty) begin
        m_pop(i, v);
        if (!fwft[i]) begin
          m_rdata[i] = v;
          m_valid[i] = 1'b1;
        end
      end
      if (wr_en[i] && !is_full) m_push(i, wr_data[i]);
    end
  endtask

  task automatic check_inst(input int i);
    int sz;
    sz = m_size(i);
    chk($sformatf("u%0d.cnt", i),    32'(cnt[i]),    32'(sz));
    chk($sformatf("u%0d.full", i),   32'(full[i]),   32'(sz == depth[i]));
    chk($sformatf("u%0d.afull", i),  32'(afull[i]),  32'(sz >= afull_t[i]));
    chk($sformatf("u%0d.empty", i),  32'(empty[i]),  32'(sz == 0));
    chk($sformatf("u%0d.aempty", i), 32'(aempty[i]), 32'(sz <= aempty_t[i]));
    chk($sformatf("u%0d.ovf", i),    32'(ovf[i]),    32'(m_ovf[i]));
    chk($sformatf("u%0d.udf", i),    32'(udf[i]),    32'(m_udf[i]));
    if (fwft[i]) begin
      chk($sformatf("u%0d.valid", i), 32'(valid[i]), 32'(sz != 0));
      if (sz != 0) chk($sformatf("u%0d.head", i), 32'(rd_data[i]), 32'(m_head(i)));
    end else begin
      chk($sformatf("u%0d.valid", i), 32'(valid[i]),   32'(m_valid[i]));
      chk($sformatf("u%0d.data", i),  32'(rd_data[i]), 32'(m_rdata[i]));
    end
  endtask

  task automatic set(input int i, input bit w, input bit r, input bit c, input logic [7:0] d);
    wr_en[i]   = w;
    rd_en[i]   = r;
    clr[i]     = c;
    wr_data[i] = d;
  endtask

  task automatic idle();
    set(0, 1'b0, 1'b0, 1'b0, 8'h00);
    set(1, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // Inputs change on the falling edge; outputs are checked 1 ns after rising.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check_inst(0);
    check_inst(1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    rst_n = 1'b1;

    // Standard depth-5: fill, overflow, drain in order.
    for (int k = 0; k < 5; k++) begin
      set(0, 1'b1, 1'b0, 1'b0, 8'h11 + 8'(k));
      tick();
    end
    chk("std_full", 32'(full[0]), 32'd1);
    chk("std_cnt5", 32'(cnt[0]), 32'd5);
    set(0, 1'b1, 1'b0, 1'b0, 8'h66);
    tick();
    chk("std_ovf", 32'(ovf[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      set(0, 1'b0, 1'b1, 1'b0, 8'h00);
      tick();
      chk("std_rd_order", 32'(rd_data[0]), 32'h11 + 32'(k));
    end
    idle();
    tick();
    chk("std_empty", 32'(empty[0]), 32'd1);

    // Pointer wrap: 3 in/out, then 5 in/out.
    for (int k = 0; k < 3; k++) begin set(0, 1'b1, 1'b0, 1'b0, 8'($urandom)); tick(); end
    for (int k = 0; k < 3; k++) begin set(0, 1'b0, 1'b1, 1'b0, 8'h00); tick(); end
    for (int k = 0; k < 5; k++) begin set(0, 1'b1, 1'b0, 1'b0, 8'($urandom)); tick(); end
    for (int k = 0; k < 5; k++) begin set(0, 1'b0, 1'b1, 1'b0, 8'h00); tick(); end
    idle();

    // FWFT depth-4: zero-latency head, pop empties.
    set(1, 1'b1, 1'b0, 1'b0, 8'hA5);
    tick();
    chk("fwft_head", 32'(rd_data[1]), 32'hA5);
    chk("fwft_valid", 32'(valid[1]), 32'd1);
    set(1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("fwft_pop_empty", 32'(empty[1]), 32'd1);

    // Fill with thresholds, then simultaneous ops at full and mid-level.
    for (int k = 0; k < 4; k++) begin
      set(1, 1'b1, 1'b0, 1'b0, 8'hB0 + 8'(k));
      tick();
      chk("thr_afull", 32'(afull[1]), 32'(k + 1 >= 3));
      chk("thr_aempty", 32'(aempty[1]), 32'(k + 1 <= 1));
    end
    set(1, 1'b1, 1'b1, 1'b0, 8'hCC);
    tick();
    chk("sim_full_cnt", 32'(cnt[1]), 32'd3);
    chk("sim_full_ovf", 32'(ovf[1]), 32'd1);
    set(1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    set(1, 1'b1, 1'b1, 1'b0, 8'hDD);
    tick();
    chk("sim_mid_cnt", 32'(cnt[1]), 32'd2);

    // Flush, underflow on empty, then flush racing a write.
    set(1, 1'b0, 1'b0, 1'b1, 8'h00);
    tick();
    set(1, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    chk("udf_set", 32'(udf[1]), 32'd1);
    chk("udf_cnt0", 32'(cnt[1]), 32'd0);
    for (int k = 0; k < 2; k++) begin set(1, 1'b1, 1'b0, 1'b0, 8'hE0 + 8'(k)); tick(); end
    set(1, 1'b1, 1'b0, 1'b1, 8'hEE);
    tick();
    chk("clr_cnt", 32'(cnt[1]), 32'd0);
    chk("clr_udf", 32'(udf[1]), 32'd0);
    idle();
    tick();

    // Random traffic: write-heavy then read-heavy, occasional flush.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        set(i,
            (n < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            (n < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 63) == 0),
            8'($urandom));
      end
      tick();
    end

    // Async reset in the middle of a burst.
    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 2; i++) set(i, 1'b1, ($urandom_range(0, 1) == 1), 1'b0, 8'($urandom));
      tick();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_inst(0);
    check_inst(1);
    idle();
    @(negedge clk);
    check_inst(0);
    check_inst(1);
    rst_n = 1'b1;
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < 2; i++) begin
        set(i, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), 1'b0, 8'($urandom));
      end
      tick();
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_mode_s_ext.md
# fifo_mode_s_ext

Parametrised single-clock FIFO for the base library. It generalises the synchronous FIFO with non-power-of-two depth and selectable standard or first-word-fall-through (FWFT) read mode. It also adds programmable almost-full/almost-empty flags, an occupancy count, sticky overflow/underflow error flags and a synchronous flush. It sits between any two same-clock producer/consumer stages that need elastic buffering with early back-pressure.

## Interface
- DATA_WIDTH, 32, data word width (≥1)
- FIFO_DEPTH, 8, number of entries; any value ≥2, power of two not required
- FWFT_MODE, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRES, FIFO_DEPTH-1, o_wr_afull asserts when count ≥ this value
- AEMPTY_THRES, 1, o_rd_aempty asserts when count ≤ this value
- PTRS_WIDTH, $clog2(FIFO_DEPTH), pointer width (derived, do not override)
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), count width (derived, do not override)

Ports:
- i_clk  in  1  clock; all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_clr  in  1  synchronous flush
- i_wr_en  in  1  write request
- i_wr_data  in  DATA_WIDTH  write data
- o_wr_full  out  1  count == FIFO_DEPTH
- o_wr_afull  out  1  count ≥ AFULL_THRES
- o_ovf  out  1  sticky: write requested while full
- i_rd_en  in  1  read request (standard) / head acknowledge (FWFT)
- o_rd_data  out  DATA_WIDTH  read data
- o_rd_valid  out  1  o_rd_data is valid (see Operation)
- o_rd_empty  out  1  count == 0
- o_rd_aempty  out  1  count ≤ AEMPTY_THRES
- o_udf  out  1  sticky: read requested while empty
- o_cnt  out  CNT_WIDTH  current occupancy

## Operation
- Accepted write: wr_acc = i_wr_en & !o_wr_full & !i_clr.
- Accepted read: rd_acc = i_rd_en & !o_rd_empty & !i_clr.
- A full FIFO rejects a write even when a read is accepted in the same cycle. An empty FIFO rejects a read even when a write is accepted in the same cycle.
- Count update: +1 on write only, −1 on read only, unchanged on both or neither. It never leaves 0..FIFO_DEPTH.
- Pointers advance by 1 on their accepted operation and wrap from FIFO_DEPTH−1 to 0 (modulo, not bit overflow).
- Storage is an array of FIFO_DEPTH words, reset to 0 and written at wr_ptr on wr_acc.
- Standard mode:
  - On rd_acc, mem[rd_ptr] is registered into o_rd_data and o_rd_valid pulses high for the next cycle only.
  - o_rd_data holds its value otherwise.
- FWFT mode:
  - o_rd_data = mem[rd_ptr] combinationally and o_rd_valid = !o_rd_empty.
  - rd_acc pops the head.
- o_ovf sets on i_wr_en & o_wr_full. o_udf sets on i_rd_en & o_rd_empty. Both stay set until i_clr or reset.
- i_clr has priority over everything in its cycle:
  - Pointers, count, o_ovf, o_udf and o_rd_valid go to 0.
  - Memory and the standard-mode o_rd_data register are not cleared.
- Flags are decoded from the registered count only, never from the request inputs.
- Reset values: o_cnt=0, o_rd_empty=1, o_rd_aempty=1 (for AEMPTY_THRES≥0), o_wr_full=0, o_wr_afull=0, o_ovf=0, o_udf=0, o_rd_valid=0, o_rd_data=0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).

## Timing
- Write at edge N: count and flags update after edge N. The data is readable from cycle N+1 (FWFT: o_rd_data valid at N+1).
- Standard read accepted at edge N: data and o_rd_valid appear after edge N, one-cycle latency.
- FWFT read: zero-latency head; the next word is presented after the popping edge.
- Full/afull/empty/aempty deassert or assert one edge after the accepted operation causing them.
- Sticky flags assert on the edge sampling the offending request.
- Throughput is one write and one read per cycle, sustained, when neither full nor empty.

## Structure
- Package base_pkg holds typedef enum fifo_mode_e {FIFO_MODE_STD, FIFO_MODE_FWFT}, plus a function clog2p1(n) for CNT_WIDTH.
- Sub-module fifo_ptr_wrap #(DEPTH): an enable-driven modulo counter with async reset. Instantiate it twice (write and read pointers).
- Standard-mode read data register reuses reg_rst_y_mode_a_en_y.
- Elaboration check: error if FIFO_DEPTH<2, AFULL_THRES>FIFO_DEPTH, or AEMPTY_THRES≥FIFO_DEPTH.

## Test plan
- DEPTH=5, STD: write 0x11..0x15 → o_wr_full=1, o_cnt=5. A sixth write → o_ovf=1, contents unchanged. Read 5 → 0x11..0x15 each one cycle after i_rd_en, then o_rd_empty=1.
- DEPTH=5, wrap: 3 writes, 3 reads, then 5 writes and 5 reads → data order preserved across pointer wrap 4→0.
- FWFT, DEPTH=4: write 0xA5 at edge N → o_rd_data=0xA5 and o_rd_valid=1 in cycle N+1. i_rd_en for one cycle → o_rd_empty=1 next cycle.
- Simultaneous: full (cnt=4) with wr+rd → read accepted, write rejected, o_cnt=3, o_ovf=1. Then cnt=2 with wr+rd → cnt stays 2.
- Thresholds AFULL=3, AEMPTY=1, DEPTH=4: fill 0→4 → afull rises at cnt=3. aempty is 1 at cnt 0 and 1, 0 at cnt 2.
- Empty read → o_udf=1, o_cnt stays 0. i_clr asserted together with wr_en at cnt=2 → cnt=0, o_udf=0, write ignored. Async reset mid-burst → all outputs at reset values immediately.
